// File: rtl/edge_row_profiler_if.sv
// Pixel-stream and result bundle between the Sobel edge stage and the row profiler.
// The master drives the edge stream and threshold; the slave returns map, row and frame results.
interface edge_row_profiler_if;
    logic [11:0] iEdge;
    logic        iDVAL;
    logic        iFVAL;
    logic [11:0] iThresh;
    logic        oBinary;
    logic        oBinDVAL;
    logic [11:0] oRowCount;
    logic [10:0] oRowIdx;
    logic        oRowValid;
    logic [10:0] oMaxRow;
    logic [11:0] oMaxCount;
    logic        oFrameDone;
    logic        oOverflow;

    modport master (
        output iEdge, iDVAL, iFVAL, iThresh,
        input  oBinary, oBinDVAL, oRowCount, oRowIdx, oRowValid,
               oMaxRow, oMaxCount, oFrameDone, oOverflow
    );

    modport slave (
        input  iEdge, iDVAL, iFVAL, iThresh,
        output oBinary, oBinDVAL, oRowCount, oRowIdx, oRowValid,
               oMaxRow, oMaxCount, oFrameDone, oOverflow
    );
endinterface

// File: rtl/edge_row_profiler.sv
// Thresholds the edge-magnitude stream into a binary map, counts edge pixels per row
// and reports the strongest row of each frame.
module edge_row_profiler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic              iCLK,
    input  logic              iRST,
    edge_row_profiler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LINE, GAP} state_t;

    localparam logic [11:0] WIDTH_LIM  = 12'(WIDTH);
    localparam logic [11:0] HEIGHT_LIM = 12'(HEIGHT);

    state_t      state, stateNext;
    logic        fvalQ;
    logic [11:0] thrQ;
    logic [11:0] colCnt, edgeCnt, maxCnt;
    logic [10:0] rowIdx, maxRow;

    logic        fvalRise, pixValid, hit, rowInRange;
    logic        frameStart, countPix, rowClose, frameEnd;
    logic [11:0] effThr, colBase, edgeBase, colNext, edgeNext, maxCntNext;
    logic [10:0] maxRowNext;

    assign fvalRise = !fvalQ && bus.iFVAL;
    assign pixValid = bus.iDVAL && bus.iFVAL;
    // The pixel arriving with the frame rise is judged against the new threshold.
    assign effThr   = frameStart ? bus.iThresh : thrQ;
    assign hit      = (bus.iEdge >= effThr);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // In LINE/GAP iFVAL was high last cycle, so iFVAL low there is a falling edge.
    always_comb begin
        stateNext  = state;
        frameStart = 1'b0;
        countPix   = 1'b0;
        rowClose   = 1'b0;
        frameEnd   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fvalRise) begin
                    frameStart = 1'b1;
                    if (bus.iDVAL) begin
                        countPix  = 1'b1;
                        stateNext = LINE;
                    end else begin
                        stateNext = GAP;
                    end
                end
            end
            GAP: begin
                if (!bus.iFVAL) begin
                    frameEnd  = 1'b1;
                    stateNext = IDLE;
                end else if (bus.iDVAL) begin
                    countPix  = 1'b1;
                    stateNext = LINE;
                end
            end
            LINE: begin
                if (!bus.iFVAL) begin
                    rowClose  = 1'b1;
                    frameEnd  = 1'b1;
                    stateNext = IDLE;
                end else if (!bus.iDVAL) begin
                    rowClose  = 1'b1;
                    stateNext = GAP;
                end else begin
                    countPix = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        colBase  = frameStart ? 12'd0 : colCnt;
        edgeBase = frameStart ? 12'd0 : edgeCnt;
        colNext  = colBase;
        edgeNext = edgeBase;
        if (colBase < WIDTH_LIM) begin
            colNext = colBase + 12'd1;
            if (hit) begin
                edgeNext = edgeBase + 12'd1;
            end
        end
    end

    // Strict compare: on a tie the earlier row keeps the maximum.
    assign rowInRange = ({1'b0, rowIdx} < HEIGHT_LIM);
    always_comb begin
        maxCntNext = maxCnt;
        maxRowNext = maxRow;
        if (rowClose && rowInRange && (edgeCnt > maxCnt)) begin
            maxCntNext = edgeCnt;
            maxRowNext = rowIdx;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalQ          <= 1'b0;
            thrQ           <= '0;
            colCnt         <= '0;
            edgeCnt        <= '0;
            rowIdx         <= '0;
            maxCnt         <= '0;
            maxRow         <= '0;
            bus.oBinary    <= 1'b0;
            bus.oBinDVAL   <= 1'b0;
            bus.oRowCount  <= '0;
            bus.oRowIdx    <= '0;
            bus.oRowValid  <= 1'b0;
            bus.oMaxRow    <= '0;
            bus.oMaxCount  <= '0;
            bus.oFrameDone <= 1'b0;
            bus.oOverflow  <= 1'b0;
        end else begin
            fvalQ          <= bus.iFVAL;
            bus.oBinary    <= pixValid && hit;
            bus.oBinDVAL   <= pixValid;
            bus.oRowValid  <= 1'b0;
            bus.oFrameDone <= 1'b0;

            if (frameStart) begin
                thrQ          <= bus.iThresh;
                rowIdx        <= '0;
                maxCnt        <= '0;
                maxRow        <= '0;
                colCnt        <= '0;
                edgeCnt       <= '0;
                bus.oOverflow <= 1'b0;
            end

            if (countPix) begin
                colCnt  <= colNext;
                edgeCnt <= edgeNext;
            end

            if (rowClose) begin
                colCnt  <= '0;
                edgeCnt <= '0;
                maxCnt  <= maxCntNext;
                maxRow  <= maxRowNext;
                if (rowIdx != 11'h7FF) begin
                    rowIdx <= rowIdx + 11'd1;
                end
                if (rowInRange) begin
                    bus.oRowValid <= 1'b1;
                    bus.oRowCount <= edgeCnt;
                    bus.oRowIdx   <= rowIdx;
                end else begin
                    bus.oOverflow <= 1'b1;
                end
            end

            if (frameEnd) begin
                bus.oFrameDone <= 1'b1;
                bus.oMaxRow    <= maxRowNext;
                bus.oMaxCount  <= maxCntNext;
            end
        end
    end
endmodule
